// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM front-end controller.
package ram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is client A, bit 1 is client B.
// The pointer remembers the last granted client; on a tie the other one wins.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Last-grant pointer; starts at B so A wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= CLIENT_B;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // One-hot grant from requests and pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == CLIENT_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves only when the granted request is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && (gnt != 2'b00)) begin
            ptr_d = gnt[1] ? CLIENT_B : CLIENT_A;
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Front-end for the dual-port RAM: initialisation sweep, host write
// pass-through, and round-robin sharing of the read port between A and B.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | sweeping every address with INIT_VALUE, all requesters held
// RUN   | host writes pass through, A/B reads arbitrated round-robin
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  h_wr_valid,
    output logic                  h_wr_ready,
    input  logic [ADDR_WIDTH-1:0] h_wr_addr,
    input  logic [DATA_WIDTH-1:0] h_wr_data,
    input  logic                  a_rd_valid,
    output logic                  a_rd_ready,
    input  logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic                  b_rd_valid,
    output logic                  b_rd_ready,
    input  logic [ADDR_WIDTH-1:0] b_rd_addr,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  wr_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    ctrl_state_e           state_q;
    ctrl_state_e           state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;

    logic [1:0]            rd_req;
    logic [1:0]            rd_gnt;
    logic                  rd_accept;

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: leave INIT after the last address has been written.
    // The counter wraps back to 0 on that same cycle and then sits idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
                state_d = RUN;
            end
        end
    end

    // Write port and status outputs per state.
    always_comb begin
        wr_enb     = 1'b0;
        wr_addr    = h_wr_addr;
        wr_data    = h_wr_data;
        h_wr_ready = 1'b0;
        init_done  = 1'b0;
        case (state_q)
            INIT: begin
                wr_enb  = 1'b1;
                wr_addr = cnt_q;
                wr_data = INIT_VALUE;
            end
            RUN: begin
                wr_enb     = h_wr_valid;
                h_wr_ready = 1'b1;
                init_done  = 1'b1;
            end
            default: begin
                wr_enb = 1'b0;
            end
        endcase
    end

    // Reads are only offered to the arbiter once the sweep is done.
    always_comb begin
        rd_req = {b_rd_valid, a_rd_valid} & {2{state_q == RUN}};
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req),
        .accept (rd_accept),
        .gnt    (rd_gnt)
    );

    // Grant drives ready directly, so any grant is an accepted request.
    always_comb begin
        a_rd_ready = rd_gnt[0];
        b_rd_ready = rd_gnt[1];
        rd_accept  = (a_rd_valid && rd_gnt[0]) || (b_rd_valid && rd_gnt[1]);
        rd_enb     = rd_accept;
        rd_addr    = rd_gnt[1] ? b_rd_addr : a_rd_addr;
    end

    // Response tag follows the RAM's one-cycle read latency; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= CLIENT_A;
        end else begin
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                rsp_id_q <= rd_gnt[1] ? CLIENT_B : CLIENT_A;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rd_data;

endmodule

// File: tb/tb_ram_port_ctrl.sv
module tb_ram_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam logic [DW-1:0] IV = 8'hA5;

    logic          clk;
    logic          rst;
    logic          h_wr_valid;
    logic          h_wr_ready;
    logic [AW-1:0] h_wr_addr;
    logic [DW-1:0] h_wr_data;
    logic          a_rd_valid;
    logic          a_rd_ready;
    logic [AW-1:0] a_rd_addr;
    logic          b_rd_valid;
    logic          b_rd_ready;
    logic [AW-1:0] b_rd_addr;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          wr_enb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_enb;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int checks;
    int failures;

    ram_port_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE (IV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .h_wr_valid (h_wr_valid),
        .h_wr_ready (h_wr_ready),
        .h_wr_addr  (h_wr_addr),
        .h_wr_data  (h_wr_data),
        .a_rd_valid (a_rd_valid),
        .a_rd_ready (a_rd_ready),
        .a_rd_addr  (a_rd_addr),
        .b_rd_valid (b_rd_valid),
        .b_rd_ready (b_rd_ready),
        .b_rd_addr  (b_rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .wr_enb     (wr_enb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_enb     (rd_enb),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM: registered read, read-before-write.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
        rd_q = 8'h00;
    end
    always @(posedge clk) begin
        if (rd_enb) rd_q <= mem[rd_addr];
        if (wr_enb) mem[wr_addr] <= wr_data;
    end
    assign rd_data = rd_q;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic          bv;
        logic [AW-1:0] ba;
        logic          hv;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          e_ardy;
        logic          e_brdy;
        logic [AW-1:0] e_raddr;
        logic          e_rspv;
        logic          e_rspid;
        logic [DW-1:0] e_rspd;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic av, input logic [AW-1:0] aa,
                                input logic bv, input logic [AW-1:0] ba,
                                input logic hv, input logic [AW-1:0] ha,
                                input logic [DW-1:0] hd,
                                input logic ear, input logic ebr,
                                input logic [AW-1:0] era,
                                input logic erv, input logic eri,
                                input logic [DW-1:0] erd);
        vec_t v;
        v.av = av; v.aa = aa; v.bv = bv; v.ba = ba;
        v.hv = hv; v.ha = ha; v.hd = hd;
        v.e_ardy = ear; v.e_brdy = ebr; v.e_raddr = era;
        v.e_rspv = erv; v.e_rspid = eri; v.e_rspd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        h_wr_valid = 1'b0; h_wr_addr = '0; h_wr_data = '0;
        a_rd_valid = 1'b0; a_rd_addr = '0;
        b_rd_valid = 1'b0; b_rd_addr = '0;

        //        av aa  bv ba  hv ha  hd     ardy brdy raddr rspv id rspd
        vecs[0]  = mk(0, 0,  0, 0,  0, 0,  8'h00, 0, 0, 0,  1, 0, 8'hA5);
        vecs[1]  = mk(1, 5,  0, 0,  1, 5,  8'h3C, 1, 0, 5,  0, 0, 8'h00);
        vecs[2]  = mk(1, 5,  0, 0,  0, 0,  8'h00, 1, 0, 5,  1, 0, 8'hA5);
        vecs[3]  = mk(0, 0,  0, 0,  0, 0,  8'h00, 0, 0, 0,  1, 0, 8'h3C);
        vecs[4]  = mk(0, 0,  1, 2,  0, 0,  8'h00, 0, 1, 2,  0, 0, 8'h00);
        vecs[5]  = mk(0, 0,  1, 2,  0, 0,  8'h00, 0, 1, 2,  1, 1, 8'hA5);
        vecs[6]  = mk(0, 0,  1, 2,  0, 0,  8'h00, 0, 1, 2,  1, 1, 8'hA5);
        vecs[7]  = mk(1, 1,  1, 2,  0, 0,  8'h00, 1, 0, 1,  1, 1, 8'hA5);
        vecs[8]  = mk(1, 1,  1, 2,  0, 0,  8'h00, 0, 1, 2,  1, 0, 8'hA5);
        vecs[9]  = mk(1, 1,  1, 2,  0, 0,  8'h00, 1, 0, 1,  1, 1, 8'hA5);
        vecs[10] = mk(1, 1,  1, 2,  0, 0,  8'h00, 0, 1, 2,  1, 0, 8'hA5);
        vecs[11] = mk(0, 0,  0, 0,  0, 0,  8'h00, 0, 0, 0,  1, 1, 8'hA5);
        vecs[12] = mk(0, 0,  0, 0,  1, 15, 8'h77, 0, 0, 0,  0, 0, 8'h00);
        vecs[13] = mk(0, 0,  1, 15, 0, 0,  8'h00, 0, 1, 15, 0, 0, 8'h00);
        vecs[14] = mk(1, 15, 1, 0,  0, 0,  8'h00, 1, 0, 15, 1, 1, 8'h77);
        vecs[15] = mk(0, 0,  0, 0,  0, 0,  8'h00, 0, 0, 0,  1, 0, 8'h77);

        // Reset state.
        next_cycle();
        @(negedge clk);
        check("rst_wr_enb", 32'(wr_enb), 32'd1);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_enb", 32'(rd_enb), 32'd0);
        check("rst_readies", 32'({h_wr_ready, a_rd_ready, b_rd_ready}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Sweep with A already requesting addr 7.
        next_cycle();
        rst = 1'b0;
        a_rd_valid = 1'b1;
        a_rd_addr = 4'd7;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            check("sweep_wr_enb", 32'(wr_enb), 32'd1);
            check("sweep_wr_addr", 32'(wr_addr), 32'(i));
            check("sweep_wr_data", 32'(wr_data), 32'(IV));
            check("sweep_a_ready", 32'(a_rd_ready), 32'd0);
            check("sweep_h_ready", 32'(h_wr_ready), 32'd0);
            check("sweep_init_done", 32'(init_done), 32'd0);
        end
        next_cycle();
        @(negedge clk);
        check("run_init_done", 32'(init_done), 32'd1);
        check("run_h_ready", 32'(h_wr_ready), 32'd1);
        check("run_first_accept", 32'(a_rd_ready), 32'd1);
        check("run_rd_enb", 32'(rd_enb), 32'd1);
        check("run_rd_addr", 32'(rd_addr), 32'd7);

        // Table-driven RUN traffic.
        for (int v = 0; v < 16; v++) begin
            next_cycle();
            a_rd_valid = vecs[v].av; a_rd_addr = vecs[v].aa;
            b_rd_valid = vecs[v].bv; b_rd_addr = vecs[v].ba;
            h_wr_valid = vecs[v].hv; h_wr_addr = vecs[v].ha; h_wr_data = vecs[v].hd;
            @(negedge clk);
            check($sformatf("v%0d_a_ready", v), 32'(a_rd_ready), 32'(vecs[v].e_ardy));
            check($sformatf("v%0d_b_ready", v), 32'(b_rd_ready), 32'(vecs[v].e_brdy));
            check($sformatf("v%0d_rd_enb", v), 32'(rd_enb), 32'(vecs[v].e_ardy | vecs[v].e_brdy));
            if (vecs[v].e_ardy | vecs[v].e_brdy)
                check($sformatf("v%0d_rd_addr", v), 32'(rd_addr), 32'(vecs[v].e_raddr));
            check($sformatf("v%0d_wr_enb", v), 32'(wr_enb), 32'(vecs[v].hv));
            if (vecs[v].hv) begin
                check($sformatf("v%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].ha));
                check($sformatf("v%0d_wr_data", v), 32'(wr_data), 32'(vecs[v].hd));
            end
            check($sformatf("v%0d_h_ready", v), 32'(h_wr_ready), 32'd1);
            check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].e_rspv));
            if (vecs[v].e_rspv) begin
                check($sformatf("v%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].e_rspid));
                check($sformatf("v%0d_rsp_data", v), 32'(rsp_data), 32'(vecs[v].e_rspd));
            end
        end

        // Reset while a read is being accepted: the response is dropped.
        next_cycle();
        h_wr_valid = 1'b0;
        b_rd_valid = 1'b0;
        a_rd_valid = 1'b1;
        a_rd_addr = 4'd3;
        rst = 1'b1;
        next_cycle();
        a_rd_valid = 1'b0;
        @(negedge clk);
        check("rstrun_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstrun_init_done", 32'(init_done), 32'd0);
        check("rstrun_wr_addr", 32'(wr_addr), 32'd0);

        // Mid-sweep reset at address 9 restarts from 0.
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            if (i == 9) rst = 1'b1;
            @(negedge clk);
            check("pre_wr_addr", 32'(wr_addr), 32'(i));
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("restart_wr_addr", 32'(wr_addr), 32'd0);
        check("restart_init_done", 32'(init_done), 32'd0);
        for (int i = 1; i < 16; i++) begin
            next_cycle();
            @(negedge clk);
            check("resweep_wr_addr", 32'(wr_addr), 32'(i));
            check("resweep_init_done", 32'(init_done), 32'd0);
        end

        // Continuous contention after reset: A first, then alternating.
        next_cycle();
        a_rd_valid = 1'b1; a_rd_addr = 4'd1;
        b_rd_valid = 1'b1; b_rd_addr = 4'd2;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("alt_init_done", 32'(init_done), 32'd1);
            check("alt_a_ready", 32'(a_rd_ready), 32'((k % 2) == 0));
            check("alt_b_ready", 32'(b_rd_ready), 32'((k % 2) == 1));
            check("alt_rd_addr", 32'(rd_addr), ((k % 2) == 0) ? 32'd1 : 32'd2);
            check("alt_rsp_valid", 32'(rsp_valid), 32'(k > 0));
            if (k > 0) check("alt_rsp_id", 32'(rsp_id), 32'((k - 1) % 2));
        end
        next_cycle();
        a_rd_valid = 1'b0;
        b_rd_valid = 1'b0;
        @(negedge clk);
        check("alt_last_rsp_valid", 32'(rsp_valid), 32'd1);
        check("alt_last_rsp_id", 32'(rsp_id), 32'd1);
        check("alt_last_rsp_data", 32'(rsp_data), 32'(IV));
        check("alt_idle_rd_enb", 32'(rd_enb), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Front-end controller for the dual-port RAM. After reset it sequences the write port through an initialisation sweep that fills every location with `INIT_VALUE`. It then passes host writes straight through to the write port and shares the read port between two read clients, A and B, under round-robin arbitration. Each read returns a response tagged with the requesting client's id. The block sits between the testbench/system requesters and the RAM's `wr_*`/`rd_*` pins.

## Interface
Parameters:
- `ADDR_WIDTH`, 4, RAM address width; depth = 2**ADDR_WIDTH
- `DATA_WIDTH`, 8, RAM data width
- `INIT_VALUE`, 0, word written to every location during the sweep

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `h_wr_valid` in 1, `h_wr_ready` out 1: host write handshake
- `h_wr_addr` in ADDR_WIDTH, `h_wr_data` in DATA_WIDTH: host write address and data
- `a_rd_valid` in 1, `a_rd_ready` out 1, `a_rd_addr` in ADDR_WIDTH: client A read request
- `b_rd_valid` in 1, `b_rd_ready` out 1, `b_rd_addr` in ADDR_WIDTH: client B read request
- `rsp_valid` out 1: read response valid
- `rsp_id` out 1: response owner (0=A, 1=B)
- `rsp_data` out DATA_WIDTH: read response data
- `init_done` out 1: high once the sweep has completed
- `wr_enb` out 1, `wr_addr` out ADDR_WIDTH, `wr_data` out DATA_WIDTH: RAM write port
- `rd_enb` out 1, `rd_addr` out ADDR_WIDTH: RAM read port
- `rd_data` in DATA_WIDTH: RAM read data, valid the cycle after `rd_enb`

## Operation
- FSM has two states: INIT and RUN. `rst` forces INIT with the sweep counter at 0.
- INIT:
  - Each cycle: `wr_enb`=1, `wr_addr`=counter, `wr_data`=INIT_VALUE; counter increments.
  - After writing address DEPTH-1, the state goes to RUN. The counter wraps to 0 and is not used again.
  - All `*_ready`=0, `rd_enb`=0.
- RUN, write path:
  - `h_wr_ready`=1.
  - `wr_enb`=`h_wr_valid`; `wr_addr`/`wr_data` pass through combinationally.
- RUN, read path:
  - If exactly one of A/B is valid, that client gets ready.
  - If both are valid, the client not granted last gets ready. The last-grant pointer resets to B, so A wins the first contention.
  - At most one ready is high per cycle. The pointer updates only on an accepted request (valid&&ready).
  - On acceptance: `rd_enb`=1, `rd_addr`=granted address.
- Response:
  - `rsp_valid`=1 exactly one cycle after an accept; `rsp_id` is registered with it.
  - `rsp_data`=`rd_data` (combinational pass-through).
  - Responses cannot be back-pressured.
- Same-address read and write in the same cycle: read-before-write. The response carries the old data; no forwarding.
- `init_done`=1 in RUN, 0 in INIT.

## Timing
- While `rst` is high, the next cycle shows:
  - `wr_enb`=1 (sweep starts at addr 0)
  - `rd_enb`=0, all ready=0, `rsp_valid`=0, `rsp_id`=0, `init_done`=0
- Sweep: after `rst` falls, addresses 0..DEPTH-1 are written on consecutive cycles. `init_done` and `h_wr_ready` rise DEPTH cycles after the first sweep write.
- Ready is combinational from the valids, state and pointer. Accept-to-`rsp_valid` latency is 1 cycle.
- Throughput: one read and one write per cycle.
- `rst` mid-sweep restarts the sweep from address 0.
- `rst` in RUN drops an in-flight response: no `rsp_valid` the following cycle.

## Structure
- Package `ram_ctrl_pkg` holds:
  - `ctrl_state_e` {INIT, RUN}
  - client-id constants `CLIENT_A`=0, `CLIENT_B`=1
- Sub-module `rr_arb2`: two-requester round-robin arbiter with its pointer register. Inputs are `req[1:0]` and an accept strobe; output is a one-hot grant.

## Test plan
- Reset, then idle, with ADDR_WIDTH=4 and INIT_VALUE=8'hA5 → 16 writes to addr 0..15 of 8'hA5. `init_done` rises at cycle 16; a read of addr 7 returns 8'hA5.
- Assert `rst` at sweep address 9 → next cycle `wr_addr`=0; a full 16-cycle sweep follows.
- A and B valid continuously (A addr 1, B addr 2) → grants alternate A,B,A,B. `rsp_id` sequence is 0,1,0,1, each one cycle after its grant.
- Host writes 8'h3C to addr 5 while A reads addr 5 in the same cycle → response carries the old value 8'hA5. A read of addr 5 next cycle returns 8'h3C.
- Only B valid for 3 cycles, then A and B together → B granted each cycle, then A wins the tie.
- Read requests during INIT → ready held 0 until `init_done`; the request is accepted on the first RUN cycle.
